call_registrar: RTL and testbench

- Request-side companion to the 5-floor lift controller. It turns raw floor-button presses into held request lines req[4:0] (A..E), which feed the controller's ra..re inputs.
- It watches the controller's floor output and runs the door open/close sequence when the car sits at a requested floor. It clears that request only after the door cycle completes.
- Because the controller parks on any floor whose request is active, holding req high through the door cycle keeps the car stationary. Clearing it releases the car.

---
 rtl/call_registrar.sv | 204 ++++++++++++++++++++
 tb/tb_call_registrar.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/call_registrar.sv
// -----------------------------------------------------------------------------
// call_registrar
//
// Request-side companion to the 5-floor lift controller. Floor-button presses
// are edge-detected and latched into held request lines (req[4:0], A..E) that
// feed the controller's ra..re inputs and the button lamps. When the car sits
// at a floor with an active request, the block runs the door open/close
// sequence and clears that request only once the door has finished closing.
// Holding req high through the door cycle keeps the controller parked; the
// clear is what releases the car.
//
// Ports:
//   clk           in   1  clock, rising edge
//   rst           in   1  asynchronous, active-high reset
//   btn           in   5  floor buttons (level), bit0=A .. bit4=E, sync to clk
//   floor         in   3  current floor from lift controller, 0=A .. 4=E
//   req           out  5  registered pending requests / button lamps
//   door_open     out  1  door fully open (OPEN state)
//   door_closing  out  1  door closing (CLOSING state)
//   serving       out  3  floor index of the current door cycle
//
// Parameters:
//   DWELL      door-open duration in clk cycles (>=1)
//   CLOSE_CYC  door-closing duration in clk cycles (>=1)
//   CW         counter width, 2^CW > max(DWELL, CLOSE_CYC)
//
// Build option:
//   DOOR_REOPEN_EN  when defined, a fresh press of the serving floor's button
//                   restarts the dwell (OPEN) or reopens the door (CLOSING).
//                   When undefined, such presses are ignored.
//
// FSM states:
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | door shut, waiting for a request at the current floor
//   ST_OPEN    | door fully open, counting down the dwell time
//   ST_CLOSING | door closing; request cleared on the last closing cycle
// -----------------------------------------------------------------------------
module call_registrar #(
  parameter int DWELL     = 8,
  parameter int CLOSE_CYC = 3,
  parameter int CW        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn,
  input  logic [2:0] floor,
  output logic [4:0] req,
  output logic       door_open,
  output logic       door_closing,
  output logic [2:0] serving
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_OPEN    = 2'd1;
  localparam logic [1:0] ST_CLOSING = 2'd2;

  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
  localparam logic [CW-1:0] CLOSE_LD = CW'(CLOSE_CYC - 1);
  localparam logic [CW-1:0] CNT_ZERO = '0;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_btn_q;
  logic [4:0]    r_req;
  logic          r_door_open;
  logic          r_door_closing;
  logic [2:0]    r_serving;

  logic [4:0]    w_press;
  logic [4:0]    w_floor_oh;
  logic [4:0]    w_srv_oh;
  logic          w_req_at_floor;
  logic          w_press_srv;

  logic [1:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_open_nxt;
  logic          w_closing_nxt;
  logic [2:0]    w_serving_nxt;
  logic [4:0]    w_clr;
  logic [4:0]    w_req_nxt;

  // Rising-edge detect: a held button registers only once.
  assign w_press = btn & ~r_btn_q;

  // One-hot decodes; floor codes 5..7 decode to all-zero and are ignored.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      w_floor_oh[i] = (floor == 3'(i));
      w_srv_oh[i]   = (r_serving == 3'(i));
    end
  end

  assign w_req_at_floor = |(r_req & w_floor_oh);
  assign w_press_srv    = |(w_press & w_srv_oh);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_open_nxt    = r_door_open;
    w_closing_nxt = r_door_closing;
    w_serving_nxt = r_serving;
    w_clr         = 5'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_req_at_floor) begin
          w_state_nxt   = ST_OPEN;
          w_serving_nxt = floor;
          w_cnt_nxt     = DWELL_LD;
          w_open_nxt    = 1'b1;
          w_closing_nxt = 1'b0;
        end
      end

      ST_OPEN: begin
`ifdef DOOR_REOPEN_EN
        if (w_press_srv) begin
          w_cnt_nxt = DWELL_LD;
        end else if (r_cnt == CNT_ZERO) begin
          w_state_nxt   = ST_CLOSING;
          w_cnt_nxt     = CLOSE_LD;
          w_open_nxt    = 1'b0;
          w_closing_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
`else
        if (r_cnt == CNT_ZERO) begin
          w_state_nxt   = ST_CLOSING;
          w_cnt_nxt     = CLOSE_LD;
          w_open_nxt    = 1'b0;
          w_closing_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
`endif
      end

      ST_CLOSING: begin
`ifdef DOOR_REOPEN_EN
        if (w_press_srv) begin
          w_state_nxt   = ST_OPEN;
          w_cnt_nxt     = DWELL_LD;
          w_open_nxt    = 1'b1;
          w_closing_nxt = 1'b0;
        end else if (r_cnt == CNT_ZERO) begin
          w_state_nxt   = ST_IDLE;
          w_closing_nxt = 1'b0;
          w_clr         = w_srv_oh;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
`else
        // The latched serving index is cleared, never the live floor input,
        // so a protocol-violating floor change cannot drop the wrong request.
        if (r_cnt == CNT_ZERO) begin
          w_state_nxt   = ST_IDLE;
          w_closing_nxt = 1'b0;
          w_clr         = w_srv_oh;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
`endif
      end

      default: begin
        w_state_nxt   = ST_IDLE;
        w_open_nxt    = 1'b0;
        w_closing_nxt = 1'b0;
      end
    endcase
  end

  // Set wins over clear: a press landing on the clearing cycle keeps the bit.
  assign w_req_nxt = (r_req & ~w_clr) | w_press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_btn_q        <= 5'b0;
      r_req          <= 5'b0;
      r_door_open    <= 1'b0;
      r_door_closing <= 1'b0;
      r_serving      <= 3'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_btn_q        <= btn;
      r_req          <= w_req_nxt;
      r_door_open    <= w_open_nxt;
      r_door_closing <= w_closing_nxt;
      r_serving      <= w_serving_nxt;
    end
  end

  assign req          = r_req;
  assign door_open    = r_door_open;
  assign door_closing = r_door_closing;
  assign serving      = r_serving;

endmodule

// File: tb/tb_call_registrar.sv
// -----------------------------------------------------------------------------
// tb_call_registrar
//
// Directed, table-driven bench for call_registrar (DWELL=8, CLOSE_CYC=3).
// Each table row gives the inputs applied before a rising edge and the
// outputs expected just after it. Rows with r=1 hold the async reset.
// Expectations for the reopen-related scenarios follow DOOR_REOPEN_EN.
// -----------------------------------------------------------------------------
module tb_call_registrar;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn;
  logic [2:0] floor;
  logic [4:0] req;
  logic       door_open;
  logic       door_closing;
  logic [2:0] serving;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       r;
    logic [4:0] b;
    logic [2:0] f;
    logic [4:0] q;
    logic       o;
    logic       c;
    logic [2:0] s;
  } vec_t;

  vec_t vecs[$];

  call_registrar #(.DWELL(8), .CLOSE_CYC(3), .CW(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .floor        (floor),
    .req          (req),
    .door_open    (door_open),
    .door_closing (door_closing),
    .serving      (serving)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic r, input logic [4:0] b, input logic [2:0] f,
                     input logic [4:0] q, input logic o, input logic c,
                     input logic [2:0] s, input int n);
    vec_t v;
    v.r = r; v.b = b; v.f = f; v.q = q; v.o = o; v.c = c; v.s = s;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [4:0] q, input logic o, input logic c,
                     input logic [2:0] s);
    checks++;
    if (req !== q || door_open !== o || door_closing !== c || serving !== s) begin
      errors++;
      $display("FAIL %s row %0d: got req=%b open=%b closing=%b serving=%0d, want req=%b open=%b closing=%b serving=%0d",
               name, idx, req, door_open, door_closing, serving, q, o, c, s);
    end
  endtask

  task automatic step(input logic [4:0] b, input logic [2:0] f);
    btn   = b;
    floor = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // A: press at a floor other than the car's -> held request, door shut
    add(1, 5'b00000, 3'd0, 5'b00000, 0, 0, 3'd0, 1);
    add(0, 5'b00100, 3'd0, 5'b00100, 0, 0, 3'd0, 1);
    add(0, 5'b00000, 3'd0, 5'b00100, 0, 0, 3'd0, 4);
    // B: full door cycle at floor 3
    add(1, 5'b00000, 3'd3, 5'b00000, 0, 0, 3'd0, 1);
    add(0, 5'b01000, 3'd3, 5'b01000, 0, 0, 3'd0, 1);
    add(0, 5'b00000, 3'd3, 5'b01000, 1, 0, 3'd3, 8);
    add(0, 5'b00000, 3'd3, 5'b01000, 0, 1, 3'd3, 3);
    add(0, 5'b00000, 3'd3, 5'b00000, 0, 0, 3'd3, 2);
    // C: another floor pressed mid-OPEN stays pending
    add(1, 5'b00000, 3'd1, 5'b00000, 0, 0, 3'd0, 1);
    add(0, 5'b00010, 3'd1, 5'b00010, 0, 0, 3'd0, 1);
    add(0, 5'b00000, 3'd1, 5'b00010, 1, 0, 3'd1, 2);
    add(0, 5'b10000, 3'd1, 5'b10010, 1, 0, 3'd1, 1);
    add(0, 5'b00000, 3'd1, 5'b10010, 1, 0, 3'd1, 5);
    add(0, 5'b00000, 3'd1, 5'b10010, 0, 1, 3'd1, 3);
    add(0, 5'b00000, 3'd1, 5'b10000, 0, 0, 3'd1, 2);
    // D: button held 20 cycles -> one door cycle; re-press needed
    add(1, 5'b00000, 3'd0, 5'b00000, 0, 0, 3'd0, 1);
    add(0, 5'b00001, 3'd0, 5'b00001, 0, 0, 3'd0, 1);
    add(0, 5'b00001, 3'd0, 5'b00001, 1, 0, 3'd0, 8);
    add(0, 5'b00001, 3'd0, 5'b00001, 0, 1, 3'd0, 3);
    add(0, 5'b00001, 3'd0, 5'b00000, 0, 0, 3'd0, 8);
    add(0, 5'b00000, 3'd0, 5'b00000, 0, 0, 3'd0, 1);
    add(0, 5'b00001, 3'd0, 5'b00001, 0, 0, 3'd0, 1);
    add(0, 5'b00000, 3'd0, 5'b00001, 1, 0, 3'd0, 1);
    // E: floor codes 5..7 ignored, floor 4 (top boundary) served
    add(1, 5'b00000, 3'd5, 5'b00000, 0, 0, 3'd0, 1);
    add(0, 5'b11111, 3'd5, 5'b11111, 0, 0, 3'd0, 1);
    add(0, 5'b00000, 3'd7, 5'b11111, 0, 0, 3'd0, 1);
    add(0, 5'b00000, 3'd6, 5'b11111, 0, 0, 3'd0, 1);
    add(0, 5'b00000, 3'd4, 5'b11111, 1, 0, 3'd4, 1);
    // F: floor changes mid-cycle -> latched serving floor is cleared
    add(1, 5'b00000, 3'd1, 5'b00000, 0, 0, 3'd0, 1);
    add(0, 5'b01010, 3'd1, 5'b01010, 0, 0, 3'd0, 1);
    add(0, 5'b00000, 3'd1, 5'b01010, 1, 0, 3'd1, 1);
    add(0, 5'b00000, 3'd3, 5'b01010, 1, 0, 3'd1, 7);
    add(0, 5'b00000, 3'd3, 5'b01010, 0, 1, 3'd1, 3);
    add(0, 5'b00000, 3'd3, 5'b01000, 0, 0, 3'd1, 1);
    add(0, 5'b00000, 3'd3, 5'b01000, 1, 0, 3'd3, 1);
    // G: re-press of serving floor during the 2nd CLOSING cycle
    add(1, 5'b00000, 3'd2, 5'b00000, 0, 0, 3'd0, 1);
    add(0, 5'b00100, 3'd2, 5'b00100, 0, 0, 3'd0, 1);
    add(0, 5'b00000, 3'd2, 5'b00100, 1, 0, 3'd2, 8);
    add(0, 5'b00000, 3'd2, 5'b00100, 0, 1, 3'd2, 2);
`ifdef DOOR_REOPEN_EN
    add(0, 5'b00100, 3'd2, 5'b00100, 1, 0, 3'd2, 1);
    add(0, 5'b00000, 3'd2, 5'b00100, 1, 0, 3'd2, 7);
    add(0, 5'b00000, 3'd2, 5'b00100, 0, 1, 3'd2, 3);
    add(0, 5'b00000, 3'd2, 5'b00000, 0, 0, 3'd2, 1);
`else
    add(0, 5'b00100, 3'd2, 5'b00100, 0, 1, 3'd2, 1);
    add(0, 5'b00000, 3'd2, 5'b00000, 0, 0, 3'd2, 3);
`endif
    // H: press of serving floor on the final CLOSING cycle
    add(1, 5'b00000, 3'd2, 5'b00000, 0, 0, 3'd0, 1);
    add(0, 5'b00100, 3'd2, 5'b00100, 0, 0, 3'd0, 1);
    add(0, 5'b00000, 3'd2, 5'b00100, 1, 0, 3'd2, 8);
    add(0, 5'b00000, 3'd2, 5'b00100, 0, 1, 3'd2, 3);
`ifdef DOOR_REOPEN_EN
    add(0, 5'b00100, 3'd2, 5'b00100, 1, 0, 3'd2, 1);
`else
    add(0, 5'b00100, 3'd2, 5'b00100, 0, 0, 3'd2, 1);
`endif
    add(0, 5'b00000, 3'd2, 5'b00100, 1, 0, 3'd2, 1);

    // Reset state
    rst   = 1'b1;
    btn   = 5'b0;
    floor = 3'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_state", -1, 5'b00000, 0, 0, 3'd0);

    // Table
    foreach (vecs[i]) begin
      rst = vecs[i].r;
      step(vecs[i].b, vecs[i].f);
      chk("table", i, vecs[i].q, vecs[i].o, vecs[i].c, vecs[i].s);
    end

    // Asynchronous reset in the middle of OPEN with several requests held
    rst = 1'b1;
    step(5'b00000, 3'd3);
    rst = 1'b0;
    step(5'b01011, 3'd3);
    chk("async_pre_latch", 0, 5'b01011, 0, 0, 3'd0);
    step(5'b00000, 3'd3);
    step(5'b00000, 3'd3);
    chk("async_pre_open", 1, 5'b01011, 1, 0, 3'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", 2, 5'b00000, 0, 0, 3'd0);
    step(5'b00000, 3'd3);
    rst = 1'b0;
    step(5'b00000, 3'd3);
    chk("async_post", 3, 5'b00000, 0, 0, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
